ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single data-RAM port between two requesters: the CPU MEM stage and an external requester (program loader / debug DMA).
- Sits between the core's RAM_IN_* / RAM_OUT interface and the physical RAM.
- The CPU normally has priority. A starvation counter guarantees external progress, and a bounded burst mode lets the loader stream writes.
- Stalls the CPU pipeline whenever its access is deferred.

Parameters:
- ADDR_W, 32, address width of both requesters and the RAM.
- DATA_W, 32, data width.
- STARVE_LIMIT, 8, consecutive denied ext cycles before ext is forced a grant (1..2^CNT_W-1).
- BURST_MAX, 4, maximum consecutive ext beats in burst mode (1..2^CNT_W-1).
- CNT_W, 4, width of the starvation and burst counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU MEM stage requests an access this cycle.
- cpu_we  in  1  CPU write (1) / read (0).
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_stall  out  1  CPU access deferred this cycle; the pipeline must hold.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- ext_req  in  1  ext request; held stable until granted.
- ext_we  in  1  ext write/read.
- ext_burst  in  1  ext asks to retain the port for following beats.
- ext_addr  in  ADDR_W  ext address.
- ext_wdata  in  DATA_W  ext write data.
- ext_gnt  out  1  ext access issued to RAM this cycle.
- ext_rvalid  out  1  ext read data valid.
- ext_rdata  out  DATA_W  ext read data.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  DATA_W  RAM read data, one cycle after address.

Behaviour:
- Reset (async, rst_n=0):
  - State = ARB_CPU; starve_cnt = 0; burst_cnt = 0; rd_owner = NONE.
  - cpu_rvalid = ext_rvalid = 0.
  - The outstanding read is discarded: no rvalid pulse after reset release.
- Grant decision is combinational from current state and counters, evaluated each cycle. Exactly one of cpu_gnt/ext_gnt, or neither.
- State ARB_CPU:
  - cpu_req=1 and starve_cnt < STARVE_LIMIT: grant CPU.
  - Else if ext_req=1: grant ext.
  - Ext is granted even when cpu_req=1 if starve_cnt == STARVE_LIMIT.
- State ARB_EXT (burst): grant ext while ext_req=1; the CPU is stalled.
- Transitions:
  - ARB_CPU -> ARB_EXT when ext is granted with ext_burst=1 and BURST_MAX>1; burst_cnt loads 1.
  - ARB_EXT -> ARB_CPU when any of: ext_req=0, ext_burst=0 on a granted beat, or burst_cnt reaches BURST_MAX after this beat.
  - burst_cnt increments per granted beat and clears on exit.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle ext_req=1 and ext is not granted.
  - Clears on any ext grant or when ext_req=0.
- cpu_stall = cpu_req & ~cpu_gnt, combinational. The CPU holds its request while stalled.
- RAM mux:
  - Granted requester drives ram_addr/ram_wdata; ram_we = granted requester's we.
  - No grant: ram_we=0, ram_addr=0, ram_wdata=0.
- Read return:
  - Registered rd_owner records the requester of a granted read.
  - Next cycle, pulse that owner's rvalid for 1 cycle.
  - cpu_rdata/ext_rdata = ram_rdata, routed unconditionally; qualified by rvalid.
  - Latency: grant cycle N -> rvalid in cycle N+1.
- Writes produce no rvalid.
- Back-to-back reads by alternating owners are legal; each rvalid follows its own grant.
- Simultaneous cpu_req & ext_req, counters 0: CPU wins; ext waits.

Decomposition:
- Shared package: arbiter state enum (ARB_CPU, ARB_EXT) and owner encoding (OWN_NONE, OWN_CPU, OWN_EXT).
- One natural sub-module: arb_sat_counter (saturating/clearable counter, width CNT_W), instantiated for starve_cnt and burst_cnt.

Test Plan:
- Reset mid-read: ext read granted in cycle 5, rst_n low in cycle 6 -> ext_rvalid never asserts; all outputs 0.
- CPU only: cpu read addr 0x10, RAM returns 0xDEADBEEF -> ram_addr=0x10 cycle N, cpu_stall=0, cpu_rvalid=1 with cpu_rdata=0xDEADBEEF at N+1.
- Contention: cpu_req and ext_req both held high, STARVE_LIMIT=8 -> CPU granted 8 cycles, ext_gnt=1 and cpu_stall=1 in cycle 9, CPU resumes cycle 10.
- Burst: ext writes 0xA0..0xA5 with ext_burst=1, BURST_MAX=4, cpu_req idle -> 4 consecutive ext_gnt, 1 cycle in ARB_CPU, remaining beats continue in a new burst.
- Burst with CPU waiting: cpu_req high during 4-beat ext burst -> cpu_stall=1 for exactly 4 cycles, CPU granted cycle 5.
- Alternating reads: CPU read 0x4 cycle N, ext read 0x8 cycle N+1 -> cpu_rvalid N+1, ext_rvalid N+2, each with the matching RAM data; no cross-routing.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// rtl/ram_port_arbiter_pkg.sv - shared types for the data-RAM port arbiter
package ram_port_arbiter_pkg;

    // Arbiter mode: CPU-priority arbitration, or ext holding the port for a burst
    typedef enum logic {
        ARB_CPU = 1'b0,
        ARB_EXT = 1'b1
    } arb_state_e;

    // Requester that owns the read data returning from the RAM next cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EXT  = 2'd2
    } rd_owner_e;

    // Owner of the read issued this cycle; writes and idle cycles own nothing
    function automatic rd_owner_e read_owner(input logic cpu_gnt, input logic cpu_we,
                                             input logic ext_gnt, input logic ext_we);
        if (cpu_gnt && !cpu_we) begin
            return OWN_CPU;
        end
        if (ext_gnt && !ext_we) begin
            return OWN_EXT;
        end
        return OWN_NONE;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - CPU, ext and RAM signal bundle around the arbiter
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              ext_req;
    logic              ext_we;
    logic              ext_burst;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_gnt;
    logic              ext_rvalid;
    logic [DATA_W-1:0] ext_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        input  ext_req, ext_we, ext_burst, ext_addr, ext_wdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output ram_addr, ram_wdata, ram_we,
        input  ram_rdata
    );

    // Requesters and RAM side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        output ext_req, ext_we, ext_burst, ext_addr, ext_wdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  ram_addr, ram_wdata, ram_we,
        output ram_rdata
    );
endinterface

// File: rtl/arb_sat_counter.sv
// rtl/arb_sat_counter.sv - clearable counter that saturates at a given maximum
module arb_sat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] max_val,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Clear wins over increment; increment stops at max_val
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q < max_val)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares one data-RAM port between the CPU and an ext requester
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int BURST_MAX    = 4,
    parameter int CNT_W        = 4
) (
    input logic             clk,
    input logic             rst_n,
    ram_port_arbiter_if.slave bus
);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] BURST_LIM  = CNT_W'(BURST_MAX);
    localparam logic [CNT_W:0]   BURST_END  = (CNT_W+1)'(BURST_MAX);
    localparam logic             BURST_EN   = (BURST_MAX > 1);

    arb_state_e        state_d, state_q;
    rd_owner_e         rd_owner_d, rd_owner_q;
    logic              cpu_gnt;
    logic              ext_gnt;
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  burst_cnt;
    logic [CNT_W:0]    burst_next;
    logic              burst_at_max;
    logic              starve_inc;
    logic              burst_inc;
    logic [ADDR_W-1:0] ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_d;
    logic              ram_we_d;

    // Grant: CPU first unless ext has starved; a running burst locks the CPU out
    always_comb begin
        cpu_gnt = 1'b0;
        ext_gnt = 1'b0;
        if (state_q == ARB_CPU) begin
            if (bus.cpu_req && (starve_cnt < STARVE_MAX)) begin
                cpu_gnt = 1'b1;
            end else if (bus.ext_req) begin
                ext_gnt = 1'b1;
            end
        end else begin
            ext_gnt = bus.ext_req;
        end
    end

    // The beat granted now is the last one the burst may take
    assign burst_next   = {1'b0, burst_cnt} + (CNT_W+1)'(1);
    assign burst_at_max = (burst_next >= BURST_END);

    // Burst entry/exit; burst_cnt counts beats while the burst continues and clears on exit
    always_comb begin
        state_d   = state_q;
        burst_inc = 1'b0;
        case (state_q)
            ARB_CPU: begin
                if (ext_gnt && bus.ext_burst && BURST_EN) begin
                    state_d   = ARB_EXT;
                    burst_inc = 1'b1;
                end
            end
            ARB_EXT: begin
                if (!bus.ext_req || !bus.ext_burst || burst_at_max) begin
                    state_d = ARB_CPU;
                end else begin
                    burst_inc = 1'b1;
                end
            end
            default: state_d = ARB_CPU;
        endcase
    end

    // Ext waiting without a grant ages; any grant or withdrawn request resets the age
    assign starve_inc = bus.ext_req & ~ext_gnt;

    arb_sat_counter #(.CNT_W(CNT_W)) u_starve_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (~starve_inc),
        .inc     (starve_inc),
        .max_val (STARVE_MAX),
        .cnt     (starve_cnt)
    );

    arb_sat_counter #(.CNT_W(CNT_W)) u_burst_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (~burst_inc),
        .inc     (burst_inc),
        .max_val (BURST_LIM),
        .cnt     (burst_cnt)
    );

    // Remember who issued this cycle's read so the returning data goes to them
    always_comb begin
        rd_owner_d = read_owner(cpu_gnt, bus.cpu_we, ext_gnt, bus.ext_we);
    end

    // Arbiter state and read owner; reset drops any read still in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB_CPU;
            rd_owner_q <= OWN_NONE;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // RAM port mux: granted requester drives the port, otherwise the port is idle and zeroed
    always_comb begin
        ram_addr_d  = '0;
        ram_wdata_d = '0;
        ram_we_d    = 1'b0;
        if (cpu_gnt) begin
            ram_addr_d  = bus.cpu_addr;
            ram_wdata_d = bus.cpu_wdata;
            ram_we_d    = bus.cpu_we;
        end else if (ext_gnt) begin
            ram_addr_d  = bus.ext_addr;
            ram_wdata_d = bus.ext_wdata;
            ram_we_d    = bus.ext_we;
        end
    end

    assign bus.ram_addr   = ram_addr_d;
    assign bus.ram_wdata  = ram_wdata_d;
    assign bus.ram_we     = ram_we_d;

    assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
    assign bus.ext_gnt    = ext_gnt;

    assign bus.cpu_rvalid = (rd_owner_q == OWN_CPU);
    assign bus.ext_rvalid = (rd_owner_q == OWN_EXT);
    assign bus.cpu_rdata  = bus.ram_rdata;
    assign bus.ext_rdata  = bus.ram_rdata;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter
module tb_ram_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int RD_NONE = 0;
    localparam int RD_CPU  = 1;
    localparam int RD_EXT  = 2;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t cpu_q[$];
    exp_t ext_q[$];
    exp_t mon_e;

    logic [31:0] mem     [0:255];
    logic        mem_vld [0:255];

    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (8),
        .BURST_MAX    (4),
        .CNT_W        (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] ram_init(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : {16'hC0DE, a[15:0]};
    endfunction

    // RAM model: one-cycle read latency, written words override the init pattern
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.ram_we) begin
            mem[bus.ram_addr[9:2]]     <= bus.ram_wdata;
            mem_vld[bus.ram_addr[9:2]] <= 1'b1;
        end
        bus.ram_rdata <= (mem_vld[bus.ram_addr[9:2]] === 1'b1) ? mem[bus.ram_addr[9:2]]
                                                              : ram_init(bus.ram_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_inputs(input logic cr, input logic cw, input logic [31:0] ca,
                              input logic [31:0] cd, input logic er, input logic ew,
                              input logic eb, input logic [31:0] ea, input logic [31:0] ed);
        bus.cpu_req   = cr;
        bus.cpu_we    = cw;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
        bus.ext_req   = er;
        bus.ext_we    = ew;
        bus.ext_burst = eb;
        bus.ext_addr  = ea;
        bus.ext_wdata = ed;
    endtask

    task automatic set_idle();
        set_inputs(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Check one cycle's grant-side outputs and queue any read return expected next cycle
    task automatic tick(input string tag, input logic e_egnt, input logic e_stall,
                        input logic [31:0] e_addr, input logic e_we,
                        input int e_rd, input logic [31:0] e_data);
        exp_t e;
        @(negedge clk);
        chk({tag, ".ext_gnt"},   {31'b0, bus.ext_gnt},   {31'b0, e_egnt});
        chk({tag, ".cpu_stall"}, {31'b0, bus.cpu_stall}, {31'b0, e_stall});
        chk({tag, ".ram_addr"},  bus.ram_addr,           e_addr);
        chk({tag, ".ram_we"},    {31'b0, bus.ram_we},    {31'b0, e_we});
        e.data = e_data;
        e.cyc  = cyc + 1;
        if (e_rd == RD_CPU) cpu_q.push_back(e);
        else if (e_rd == RD_EXT) ext_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_tick();
        tick("idle", 1'b0, 1'b0, 32'h0, 1'b0, RD_NONE, 32'h0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".ext_gnt"},    {31'b0, bus.ext_gnt},    32'h0);
        chk({tag, ".cpu_stall"},  {31'b0, bus.cpu_stall},  32'h0);
        chk({tag, ".cpu_rvalid"}, {31'b0, bus.cpu_rvalid}, 32'h0);
        chk({tag, ".ext_rvalid"}, {31'b0, bus.ext_rvalid}, 32'h0);
        chk({tag, ".ram_addr"},   bus.ram_addr,            32'h0);
        chk({tag, ".ram_wdata"},  bus.ram_wdata,           32'h0);
        chk({tag, ".ram_we"},     {31'b0, bus.ram_we},     32'h0);
    endtask

    // Monitor: every rvalid must match the head of its owner's queue, on time
    always @(negedge clk) begin
        if (cpu_q.size() > 0 && cpu_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL cpu_rvalid_missing: got none expected at cycle %0d (now %0d)", cpu_q[0].cyc, cyc);
            void'(cpu_q.pop_front());
        end
        if (ext_q.size() > 0 && ext_q[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL ext_rvalid_missing: got none expected at cycle %0d (now %0d)", ext_q[0].cyc, cyc);
            void'(ext_q.pop_front());
        end
        if (bus.cpu_rvalid === 1'b1) begin
            if (cpu_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL cpu_rvalid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = cpu_q.pop_front();
                chk("cpu_rdata", bus.cpu_rdata, mon_e.data);
                chk("cpu_rvalid_cycle", cyc, mon_e.cyc);
            end
        end
        if (bus.ext_rvalid === 1'b1) begin
            if (ext_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ext_rvalid_unexpected: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = ext_q.pop_front();
                chk("ext_rdata", bus.ext_rdata, mon_e.data);
                chk("ext_rvalid_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_vld[i] = 1'b0;
        rst_n = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_quiet("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) idle_tick();

        // Ext read granted, then reset lands while its data would return
        set_inputs(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        tick("rst_rd", 1'b1, 1'b0, 32'h20, 1'b0, RD_NONE, 32'h0);
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        chk_quiet("rst_mid_read");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) idle_tick();

        // CPU-only read
        set_inputs(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick("cpu_rd", 1'b0, 1'b0, 32'h10, 1'b0, RD_CPU, 32'hDEAD_BEEF);
        set_idle();
        idle_tick();

        // Contention, no burst: 8 CPU grants, ext forced in on the 9th, CPU back on the 10th
        set_inputs(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
        for (int i = 0; i < 8; i++) tick("cont_cpu", 1'b0, 1'b0, 32'h4, 1'b0, RD_CPU, 32'hC0DE_0004);
        tick("cont_ext", 1'b1, 1'b1, 32'h8, 1'b0, RD_EXT, 32'hC0DE_0008);
        set_inputs(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick("cont_resume", 1'b0, 1'b0, 32'h4, 1'b0, RD_CPU, 32'hC0DE_0004);
        set_idle();
        idle_tick();

        // Alternating single reads
        set_inputs(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick("alt_cpu", 1'b0, 1'b0, 32'h4, 1'b0, RD_CPU, 32'hC0DE_0004);
        set_inputs(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
        tick("alt_ext", 1'b1, 1'b0, 32'h8, 1'b0, RD_EXT, 32'hC0DE_0008);
        set_idle();
        repeat (2) idle_tick();

        // Burst writes 0xA0..0xA5: a 4-beat burst, then a new burst for the rest
        for (int i = 0; i < 6; i++) begin
            set_inputs(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, (i < 5),
                       32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
            tick("burst_wr", 1'b1, 1'b0, 32'h100 + 32'(4 * i), 1'b1, RD_NONE, 32'h0);
        end
        set_idle();
        idle_tick();
        set_inputs(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick("rb_0", 1'b0, 1'b0, 32'h100, 1'b0, RD_CPU, 32'hA0);
        set_inputs(1'b1, 1'b0, 32'h10C, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick("rb_3", 1'b0, 1'b0, 32'h10C, 1'b0, RD_CPU, 32'hA3);
        set_inputs(1'b1, 1'b0, 32'h114, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick("rb_5", 1'b0, 1'b0, 32'h114, 1'b0, RD_CPU, 32'hA5);
        set_idle();
        idle_tick();

        // Burst cap: CPU arrives on beat 2, waits beats 2..4, wins the gap cycle
        set_inputs(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h180, 32'hB0);
        tick("cap_b1", 1'b1, 1'b0, 32'h180, 1'b1, RD_NONE, 32'h0);
        for (int j = 1; j < 4; j++) begin
            set_inputs(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b1,
                       32'h180 + 32'(4 * j), 32'hB0 + 32'(j));
            tick("cap_beat", 1'b1, 1'b1, 32'h180 + 32'(4 * j), 1'b1, RD_NONE, 32'h0);
        end
        set_inputs(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0, 32'h190, 32'hB4);
        tick("cap_cpu", 1'b0, 1'b0, 32'h10, 1'b0, RD_CPU, 32'hDEAD_BEEF);
        set_inputs(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h190, 32'hB4);
        tick("cap_ext", 1'b1, 1'b0, 32'h190, 1'b1, RD_NONE, 32'h0);
        set_idle();
        idle_tick();

        // Starvation-forced burst: CPU stalled for exactly the 4 ext beats
        set_inputs(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b1, 1'b1, 32'h200, 32'h70);
        for (int i = 0; i < 8; i++) tick("sb_cpu", 1'b0, 1'b0, 32'h4, 1'b0, RD_CPU, 32'hC0DE_0004);
        for (int j = 0; j < 4; j++) begin
            set_inputs(1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b1, 1'b1,
                       32'h200 + 32'(4 * j), 32'h70 + 32'(j));
            tick("sb_ext", 1'b1, 1'b1, 32'h200 + 32'(4 * j), 1'b1, RD_NONE, 32'h0);
        end
        set_inputs(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick("sb_resume", 1'b0, 1'b0, 32'h4, 1'b0, RD_CPU, 32'hC0DE_0004);
        set_idle();
        repeat (2) idle_tick();

        chk("cpu_q_drained", 32'(cpu_q.size()), 32'h0);
        chk("ext_q_drained", 32'(ext_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
